// File: rtl/noc_link_rx_buffer.sv
// Receive side of a valid/yummy credit link: buffers router flits in a
// CRED_SIZE-deep FIFO, presents unpacked fields on valid/ready, returns credits.
module noc_link_rx_buffer #(
  parameter int WIDTH      = 64,
  parameter int DAT_WIDTH  = 32,
  parameter int TYPE_WIDTH = 4,
  parameter int TID_WIDTH  = 8,
  parameter int CRED_BITS  = 2,
  parameter int CRED_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      router_data,
  input  logic                  router_valid,
  output logic                  router_yummy,
  output logic [TID_WIDTH-1:0]  nou_tid,
  output logic [TYPE_WIDTH-1:0] nou_type,
  output logic [DAT_WIDTH-1:0]  nou_data,
  output logic                  nou_valid,
  input  logic                  nou_ready,
  output logic [CRED_BITS:0]    occupancy,
  output logic                  ovf_err
);

  localparam int FIELD_W = DAT_WIDTH + TYPE_WIDTH + TID_WIDTH;
  localparam logic [CRED_BITS:0] CNT_FULL = (CRED_BITS+1)'(CRED_SIZE);

  // Consumer handshake: a flit transfers on every cycle where nou_valid and
  // nou_ready are both high; nou_valid and the fields hold steady until then,
  // and nou_ready with nou_valid low is ignored.
  logic [FIELD_W-1:0]   mem [CRED_SIZE];
  logic [CRED_BITS-1:0] wr_ptr;
  logic [CRED_BITS-1:0] rd_ptr;
  logic [CRED_BITS:0]   count;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 full;
  logic [FIELD_W-1:0]   head;

  assign push   = router_valid;
  assign pop    = nou_valid && nou_ready;
  assign full   = (count == CNT_FULL);
  assign accept = push && (!full || pop);

  // Routing header bits above the tid are intentionally dropped.
  generate
    if (WIDTH > FIELD_W) begin : g_hdr
      logic unused_hdr;
      assign unused_hdr = ^router_data[WIDTH-1:FIELD_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= router_data[FIELD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      router_yummy <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + CRED_BITS'(1);
      if (pop)    rd_ptr <= rd_ptr + CRED_BITS'(1);
      if (accept && !pop)      count <= count + (CRED_BITS+1)'(1);
      else if (pop && !accept) count <= count - (CRED_BITS+1)'(1);
      router_yummy <= pop;
      if (push && full && !pop) ovf_err <= 1'b1;
    end
  end

  assign nou_valid = (count != '0);
  assign occupancy = count;
  assign head      = nou_valid ? mem[rd_ptr] : '0;
  assign nou_data  = head[DAT_WIDTH-1:0];
  assign nou_type  = head[DAT_WIDTH+TYPE_WIDTH-1:DAT_WIDTH];
  assign nou_tid   = head[FIELD_W-1:DAT_WIDTH+TYPE_WIDTH];

endmodule

// File: tb/tb_noc_link_rx_buffer.sv
// Bench for noc_link_rx_buffer: queue-based reference model checked every
// cycle, directed timing scenarios, credit-limited streaming and random traffic.
module tb_noc_link_rx_buffer;
  localparam int W = 64;
  localparam int CRED = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] router_data;
  logic         router_valid;
  logic         router_yummy;
  logic [7:0]   nou_tid;
  logic [3:0]   nou_type;
  logic [31:0]  nou_data;
  logic         nou_valid;
  logic         nou_ready;
  logic [2:0]   occupancy;
  logic         ovf_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: stored flits, pending credit pulse, sticky overflow.
  logic [W-1:0] exp_q[$];
  logic         exp_yummy = 1'b0;
  logic         exp_ovf = 1'b0;

  noc_link_rx_buffer dut (
    .clk(clk), .rst(rst),
    .router_data(router_data), .router_valid(router_valid),
    .router_yummy(router_yummy),
    .nou_tid(nou_tid), .nou_type(nou_type), .nou_data(nou_data),
    .nou_valid(nou_valid), .nou_ready(nou_ready),
    .occupancy(occupancy), .ovf_err(ovf_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare + model update ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_yummy = 1'b0;
      exp_ovf   = 1'b0;
      chk("rst_valid", {63'd0, nou_valid}, 64'd0);
      chk("rst_yummy", {63'd0, router_yummy}, 64'd0);
      chk("rst_occ", {61'd0, occupancy}, 64'd0);
    end else begin
      int sz;
      bit do_pop;
      logic [W-1:0] hd;
      sz = exp_q.size();
      hd = (sz != 0) ? exp_q[0] : '0;
      chk("valid", {63'd0, nou_valid}, {63'd0, sz != 0});
      chk("occupancy", {61'd0, occupancy}, 64'(sz));
      chk("yummy", {63'd0, router_yummy}, {63'd0, exp_yummy});
      chk("ovf", {63'd0, ovf_err}, {63'd0, exp_ovf});
      chk("data", {32'd0, nou_data}, {32'd0, hd[31:0]});
      chk("type", {60'd0, nou_type}, {60'd0, hd[35:32]});
      chk("tid", {56'd0, nou_tid}, {56'd0, hd[43:36]});
      do_pop = (sz != 0) && nou_ready;
      exp_yummy = do_pop;
      if (do_pop) void'(exp_q.pop_front());
      if (router_valid) begin
        if (sz < CRED || do_pop) exp_q.push_back(router_data);
        else exp_ovf = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    router_valid = v;
    router_data  = d;
    nou_ready    = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    router_valid = 1'b0;
    nou_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [W-1:0] tag_flit(input int t);
    return {$urandom_range(0, 1048575) & 20'hFFFFF, 8'(t), 4'(t), 32'(t)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int credits, sent, stalls, yum;
    logic [W-1:0] f;
    rst = 1'b0;
    router_valid = 1'b0;
    router_data = '0;
    nou_ready = 1'b0;
    #23;
    rst = 1'b1;

    // idle with ready high
    repeat (10) step(1'b0, '0, 1'b1);
    #2;
    chk("idle_occ", {61'd0, occupancy}, 64'd0);

    // single flit timing
    step(1'b1, 64'h0000_0A35_DEAD_BEEF, 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    chk("single_valid", {63'd0, nou_valid}, 64'd1);
    chk("single_data", {32'd0, nou_data}, 64'hDEADBEEF);
    chk("single_type", {60'd0, nou_type}, 64'h5);
    chk("single_tid", {56'd0, nou_tid}, 64'hA3);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    #2;
    chk("single_hold", {32'd0, nou_data}, 64'hDEADBEEF);
    step(1'b0, '0, 1'b0);
    #2;
    chk("single_yummy", {63'd0, router_yummy}, 64'd1);
    chk("single_gone", {63'd0, nou_valid}, 64'd0);
    step(1'b0, '0, 1'b0);
    #2;
    chk("single_yummy_end", {63'd0, router_yummy}, 64'd0);

    // fill and overflow
    for (int t = 1; t <= 4; t++) step(1'b1, tag_flit(t), 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    chk("fill_occ", {61'd0, occupancy}, 64'd4);
    chk("fill_ovf", {63'd0, ovf_err}, 64'd0);
    step(1'b1, tag_flit(9), 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    chk("ovf_occ", {61'd0, occupancy}, 64'd4);
    chk("ovf_set", {63'd0, ovf_err}, 64'd1);
    chk("ovf_head", {32'd0, nou_data}, 64'd1);
    repeat (6) step(1'b0, '0, 1'b1);
    do_reset();

    // push while popping at full
    for (int t = 1; t <= 4; t++) step(1'b1, tag_flit(t), 1'b0);
    step(1'b1, tag_flit(5), 1'b1);
    step(1'b0, '0, 1'b0);
    #2;
    chk("pp_occ", {61'd0, occupancy}, 64'd4);
    chk("pp_ovf", {63'd0, ovf_err}, 64'd0);
    chk("pp_yummy", {63'd0, router_yummy}, 64'd1);
    chk("pp_head", {32'd0, nou_data}, 64'd2);
    repeat (6) step(1'b0, '0, 1'b1);

    // credit-limited streaming of 100 flits
    credits = CRED; sent = 0; stalls = 0; yum = 0;
    nou_ready = 1'b1;
    while (sent < 100) begin
      step(1'b0, '0, 1'b1);
      if (router_yummy) begin credits++; yum++; end
      if (credits > 0) begin
        router_valid = 1'b1;
        router_data  = tag_flit(sent + 10);
        credits--;
        sent++;
      end else stalls++;
    end
    repeat (6) begin
      step(1'b0, '0, 1'b1);
      if (router_yummy) begin credits++; yum++; end
    end
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_yummies", 64'(yum), 64'd100);
    chk("stream_credits", 64'(credits), 64'd4);

    // random traffic, including overflow pushes
    for (int i = 0; i < 1500; i++) begin
      f = {$urandom(), $urandom()};
      step(1'($urandom_range(0, 99) < 60), f, 1'($urandom_range(0, 99) < 45));
    end
    repeat (6) step(1'b0, '0, 1'b1);
    do_reset();

    // async reset mid-stream at occupancy 3
    for (int t = 1; t <= 3; t++) step(1'b1, tag_flit(t), 1'b0);
    step(1'b1, tag_flit(4), 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, nou_valid}, 64'd0);
    chk("arst_occ", {61'd0, occupancy}, 64'd0);
    chk("arst_yummy", {63'd0, router_yummy}, 64'd0);
    chk("arst_data", {32'd0, nou_data}, 64'd0);
    chk("arst_tid", {56'd0, nou_tid}, 64'd0);
    router_valid = 1'b0;
    nou_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, tag_flit(77), 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    chk("post_rst_valid", {63'd0, nou_valid}, 64'd1);
    chk("post_rst_data", {32'd0, nou_data}, 64'd77);
    chk("post_rst_occ", {61'd0, occupancy}, 64'd1);
    chk("post_rst_yummy", {63'd0, router_yummy}, 64'd0);
    repeat (4) step(1'b0, '0, 1'b1);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
